// File: rtl/instruction_fetch_pkg.sv
// Shared CPU definitions: default widths, reset PC, instruction field
// bounds and the fetch FSM state encodings.
package instruction_fetch_pkg;

  localparam int ADDR_WIDTH_DEF = 28;
  localparam int DATA_WIDTH_DEF = 32;
  localparam logic [27:0] RESET_PC_DEF = 28'h0000100;

  // Instruction field bounds: opcode [31:28], operand [27:0]
  localparam int OPC_MSB     = 31;
  localparam int OPC_LSB     = 28;
  localparam int OPERAND_MSB = 27;

  // Fetch FSM encodings
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_VALID  = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_REQ    = S_REQ,
    ST_WAIT   = S_WAIT,
    ST_VALID  = S_VALID,
    ST_HALTED = S_HALTED
  } fetch_state_e;

  // Width of the read-latency counter (latency range 1..4)
  localparam int LAT_W = 3;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction words from a
// synchronous RAM and hands them to execute over a valid/ready handshake.
// Execute can redirect, skip one word, or halt the stage.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int                    DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = ADDR_WIDTH'(RESET_PC_DEF),
  parameter int                    READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cs,
  output logic                  mem_oe,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  output logic [DATA_WIDTH-1:0] ir_data,
  output logic [ADDR_WIDTH-1:0] ir_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  input  logic                  skip,
  input  logic                  halt,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted
);

  fetch_state_e          state_r;
  logic [ADDR_WIDTH-1:0] pc_r;
  logic [LAT_W-1:0]      cnt_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic                  mem_cs_r;
  logic                  mem_oe_r;
  logic                  ir_valid_r;
  logic [DATA_WIDTH-1:0] ir_data_r;
  logic [ADDR_WIDTH-1:0] ir_pc_r;
  logic                  halted_r;

  logic                  sample_s;
  logic                  jump_s;
  logic [ADDR_WIDTH-1:0] req_pc_s;

  // Target PC for the next request: redirect beats skip; a skip on the
  // data-sample cycle also absorbs the normal increment (pc+2).
  always_comb begin
    sample_s = (state_r == ST_WAIT) && (cnt_r == LAT_W'(1));
    jump_s   = redirect_valid || skip;
    req_pc_s = pc_r;
    if (redirect_valid) begin
      req_pc_s = redirect_addr;
    end else if (skip) begin
      if (sample_s) begin
        req_pc_s = pc_r + ADDR_WIDTH'(2);
      end else begin
        req_pc_s = pc_r + ADDR_WIDTH'(1);
      end
    end else begin
      req_pc_s = pc_r;
    end
  end

  // Fetch FSM with registered RAM controls and instruction outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      pc_r       <= RESET_PC;
      cnt_r      <= LAT_W'(0);
      mem_addr_r <= ADDR_WIDTH'(0);
      mem_cs_r   <= 1'b0;
      mem_oe_r   <= 1'b0;
      ir_valid_r <= 1'b0;
      ir_data_r  <= DATA_WIDTH'(0);
      ir_pc_r    <= ADDR_WIDTH'(0);
      halted_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r    <= ST_REQ;
            mem_addr_r <= pc_r;
            mem_cs_r   <= 1'b1;
            mem_oe_r   <= 1'b1;
          end
        end
        ST_REQ, ST_WAIT, ST_VALID: begin
          if (halt) begin
            state_r    <= ST_HALTED;
            halted_r   <= 1'b1;
            ir_valid_r <= 1'b0;
            mem_cs_r   <= 1'b0;
            mem_oe_r   <= 1'b0;
          end else if (jump_s || (state_r == ST_VALID && ir_ready)) begin
            // Any in-flight read is dropped; reissue at the new PC
            state_r    <= ST_REQ;
            pc_r       <= req_pc_s;
            mem_addr_r <= req_pc_s;
            mem_cs_r   <= 1'b1;
            mem_oe_r   <= 1'b1;
            ir_valid_r <= 1'b0;
          end else if (state_r == ST_REQ) begin
            state_r <= ST_WAIT;
            cnt_r   <= LAT_W'(READ_LATENCY);
          end else if (sample_s) begin
            state_r    <= ST_VALID;
            ir_data_r  <= mem_rdata;
            ir_pc_r    <= pc_r;
            pc_r       <= pc_r + ADDR_WIDTH'(1);
            ir_valid_r <= 1'b1;
            mem_cs_r   <= 1'b0;
            mem_oe_r   <= 1'b0;
          end else if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r - LAT_W'(1);
          end else begin
            state_r <= state_r;
          end
        end
        ST_HALTED: begin
          state_r <= ST_HALTED;
        end
        default: begin
          state_r    <= ST_IDLE;
          mem_cs_r   <= 1'b0;
          mem_oe_r   <= 1'b0;
          ir_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr = mem_addr_r;
  assign mem_cs   = mem_cs_r;
  assign mem_oe   = mem_oe_r;
  assign mem_we   = 1'b0;
  assign ir_valid = ir_valid_r;
  assign ir_data  = ir_data_r;
  assign ir_pc    = ir_pc_r;
  assign pc       = pc_r;
  assign halted   = halted_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch: one default instance
// (RESET_PC='h100, latency 1) and one wrap instance (RESET_PC='hFFFFFFF,
// latency 3), each fed by a one-cycle synchronous RAM model.
module tb_instruction_fetch;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Default instance signals
  logic        start, mem_cs, mem_oe, mem_we, ir_valid, ir_ready;
  logic        redirect_valid, skip, halt, halted;
  logic [27:0] mem_addr, ir_pc, redirect_addr, pc;
  logic [31:0] mem_rdata, ir_data;

  // Wrap instance signals
  logic        b_start, b_mem_cs, b_mem_oe, b_mem_we, b_ir_valid, b_ir_ready, b_halted;
  logic [27:0] b_mem_addr, b_ir_pc, b_pc;
  logic [31:0] b_mem_rdata, b_ir_data;

  logic we_seen = 1'b0;

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ir_data(ir_data), .ir_pc(ir_pc), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .skip(skip), .halt(halt), .pc(pc),
    .halted(halted)
  );

  instruction_fetch #(.RESET_PC(28'hFFFFFFF), .READ_LATENCY(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start),
    .mem_addr(b_mem_addr), .mem_cs(b_mem_cs), .mem_oe(b_mem_oe), .mem_we(b_mem_we),
    .mem_rdata(b_mem_rdata), .ir_valid(b_ir_valid), .ir_ready(b_ir_ready),
    .ir_data(b_ir_data), .ir_pc(b_ir_pc), .redirect_valid(1'b0),
    .redirect_addr(28'h0), .skip(1'b0), .halt(1'b0), .pc(b_pc),
    .halted(b_halted)
  );

  // RAM contents: two seeded words, everything else is {4'h5, address}
  function automatic logic [31:0] ram_word(input logic [27:0] a);
    if (a == 28'h100) return 32'h20000113;
    else if (a == 28'h10F) return 32'h60000100;
    else return {4'h5, a};
  endfunction

  // Synchronous RAM models, one-cycle read
  always @(posedge clk) begin
    if (mem_cs && mem_oe) mem_rdata <= ram_word(mem_addr);
    if (b_mem_cs && b_mem_oe) b_mem_rdata <= ram_word(b_mem_addr);
    if (mem_we || b_mem_we) we_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"},       32'(pc), 32'h100);
    chk({tag, "_addr"},     32'(mem_addr), 32'h0);
    chk({tag, "_cs"},       32'(mem_cs), 32'h0);
    chk({tag, "_oe"},       32'(mem_oe), 32'h0);
    chk({tag, "_valid"},    32'(ir_valid), 32'h0);
    chk({tag, "_data"},     ir_data, 32'h0);
    chk({tag, "_irpc"},     32'(ir_pc), 32'h0);
    chk({tag, "_halted"},   32'(halted), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ir_ready = 1'b0; redirect_valid = 1'b0;
    redirect_addr = 28'h0; skip = 1'b0; halt = 1'b0;
    b_start = 1'b0; b_ir_ready = 1'b0;
    tick(); tick();
    chk_reset_vals("rst");
    chk("rst_we", 32'(mem_we), 32'h0);
    rst_n = 1'b1;
    tick();

    // Basic fetch: ir_valid 3 cycles after start
    start = 1'b1;
    tick(); start = 1'b0;
    chk("req_cs", 32'(mem_cs), 32'h1);
    chk("req_oe", 32'(mem_oe), 32'h1);
    chk("req_addr", 32'(mem_addr), 32'h100);
    chk("req_valid", 32'(ir_valid), 32'h0);
    tick();
    chk("wait_valid", 32'(ir_valid), 32'h0);
    tick();
    chk("f1_valid", 32'(ir_valid), 32'h1);
    chk("f1_data", ir_data, 32'h20000113);
    chk("f1_irpc", 32'(ir_pc), 32'h100);
    chk("f1_pc", 32'(pc), 32'h101);
    chk("f1_cs", 32'(mem_cs), 32'h0);

    // Backpressure: held for 5 cycles, no new request
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(ir_valid), 32'h1);
      chk("bp_data", ir_data, 32'h20000113);
      chk("bp_irpc", 32'(ir_pc), 32'h100);
      chk("bp_cs", 32'(mem_cs), 32'h0);
    end
    ir_ready = 1'b1;
    tick(); ir_ready = 1'b0;
    chk("hs_valid", 32'(ir_valid), 32'h0);
    chk("hs_cs", 32'(mem_cs), 32'h1);
    chk("hs_addr", 32'(mem_addr), 32'h101);

    // Redirect during WAIT: old read discarded
    tick();
    redirect_valid = 1'b1; redirect_addr = 28'h10F;
    tick(); redirect_valid = 1'b0;
    chk("rd_valid", 32'(ir_valid), 32'h0);
    chk("rd_addr", 32'(mem_addr), 32'h10F);
    chk("rd_pc", 32'(pc), 32'h10F);
    tick();
    chk("rd_wait_valid", 32'(ir_valid), 32'h0);
    tick();
    chk("rd_f_valid", 32'(ir_valid), 32'h1);
    chk("rd_f_data", ir_data, 32'h60000100);
    chk("rd_f_irpc", 32'(ir_pc), 32'h10F);
    chk("rd_f_pc", 32'(pc), 32'h110);

    // Redirect coincident with handshake in VALID
    redirect_valid = 1'b1; redirect_addr = 28'h102; ir_ready = 1'b1;
    tick(); redirect_valid = 1'b0;
    chk("rdhs_valid", 32'(ir_valid), 32'h0);
    chk("rdhs_addr", 32'(mem_addr), 32'h102);
    tick(); tick();
    chk("s_f_irpc", 32'(ir_pc), 32'h102);
    chk("s_f_pc", 32'(pc), 32'h103);
    chk("s_f_data", ir_data, 32'h50000102);

    // Skip with handshake at pc=0x103 -> next fetch at 0x104
    skip = 1'b1;
    tick(); skip = 1'b0; ir_ready = 1'b0;
    chk("sk_addr", 32'(mem_addr), 32'h104);
    chk("sk_pc", 32'(pc), 32'h104);
    chk("sk_valid", 32'(ir_valid), 32'h0);
    tick(); tick();
    chk("sk_f_irpc", 32'(ir_pc), 32'h104);
    chk("sk_f_data", ir_data, 32'h50000104);

    // Skip + redirect together: redirect wins
    skip = 1'b1; redirect_valid = 1'b1; redirect_addr = 28'h100;
    tick(); skip = 1'b0; redirect_valid = 1'b0;
    chk("skrd_addr", 32'(mem_addr), 32'h100);
    chk("skrd_pc", 32'(pc), 32'h100);
    chk("skrd_valid", 32'(ir_valid), 32'h0);

    // Skip on the sample cycle of WAIT -> pc+2, data dropped
    tick();
    skip = 1'b1;
    tick(); skip = 1'b0;
    chk("sk2_addr", 32'(mem_addr), 32'h102);
    chk("sk2_pc", 32'(pc), 32'h102);
    chk("sk2_valid", 32'(ir_valid), 32'h0);

    // Halt during REQ; start ignored afterwards
    halt = 1'b1;
    tick(); halt = 1'b0;
    chk("h_halted", 32'(halted), 32'h1);
    chk("h_cs", 32'(mem_cs), 32'h0);
    chk("h_valid", 32'(ir_valid), 32'h0);
    start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    chk("h2_halted", 32'(halted), 32'h1);
    chk("h2_cs", 32'(mem_cs), 32'h0);
    chk("h2_oe", 32'(mem_oe), 32'h0);
    chk("h2_valid", 32'(ir_valid), 32'h0);

    // Reset out of HALTED, then reset mid-WAIT asynchronously
    rst_n = 1'b0;
    #1;
    chk("hr_halted", 32'(halted), 32'h0);
    tick(); rst_n = 1'b1;
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("mw_cs", 32'(mem_cs), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    tick(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_valid", 32'(ir_valid), 32'h0);
      chk("post_rst_cs", 32'(mem_cs), 32'h0);
    end

    // Wrap instance: latency 3, PC wraps to 0
    b_start = 1'b1;
    tick(); b_start = 1'b0;
    chk("b_req_addr", 32'(b_mem_addr), 32'hFFFFFFF);
    chk("b_req_cs", 32'(b_mem_cs), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b_wait_valid", 32'(b_ir_valid), 32'h0);
    end
    tick();
    chk("b_valid", 32'(b_ir_valid), 32'h1);
    chk("b_irpc", 32'(b_ir_pc), 32'hFFFFFFF);
    chk("b_data", b_ir_data, 32'h5FFFFFFF);
    chk("b_pc_wrap", 32'(b_pc), 32'h0);
    chk("b_halted", 32'(b_halted), 32'h0);
    b_ir_ready = 1'b1;
    tick(); b_ir_ready = 1'b0;
    chk("b_next_addr", 32'(b_mem_addr), 32'h0);
    chk("b_next_cs", 32'(b_mem_cs), 32'h1);
    chk("b_next_oe", 32'(b_mem_oe), 32'h1);

    chk("we_never", 32'(we_seen), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
